ram_n: RTL and testbench

Parametrised single-port word RAM, successor to the fixed 8-word x 16-bit RAM: width and depth are parameters. A built-in clear sequencer zeroes every word after reset and on demand, and reports progress on `busy`. It serves as the general data/instruction memory building block for the CPU datapath and for larger RAM composites.

---
 rtl/ram_n.sv | 120 ++++++++++++
 tb/tb_ram_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_n.sv
// rtl/ram_n.sv - parametrised single-port word RAM with built-in clear sequencer
//
// Purpose: WIDTH x 2**ADDR_WIDTH word memory. After reset, and on a clear
// request, a sweep writes zero to every word, one word per cycle, while busy=1.
// Writes and clear requests made while busy=1 are ignored.
//
// Configuration macro: RAM_N_REGOUT_EN
//   defined   : out is registered (1-cycle read latency, read-before-write)
//   undefined : out is combinational (0-cycle read latency)
//
// Ports:
//   clk      in   1           rising-edge clock
//   rst_n    in   1           asynchronous active-low reset
//   address  in   ADDR_WIDTH  read/write address
//   in       in   WIDTH       write data
//   load     in   1           write enable
//   clear    in   1           request to zero the whole memory
//   out      out  WIDTH       read data (0 while busy)
//   busy     out  1           clear sweep in progress
module ram_n #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic                  clear,
  output logic [WIDTH-1:0]      out,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   ptr_nxt;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem [DEPTH];

  // Reset lands in CLEAR so the memory is swept to zero after release;
  // the array itself carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = in;
    case (state)
      IDLE: begin
        // clear wins over a same-cycle load
        if (clear) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else if (load) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        // The sweep port owns the memory; load and clear are ignored here.
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = '0;
        ptr_nxt   = ptr + 1'b1;  // wraps to 0 after the last word
        if (&ptr) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign busy = (state == CLEAR);

`ifdef RAM_N_REGOUT_EN
  // Captures the pre-write word, giving read-before-write on a same-address
  // access; a cycle spent in CLEAR captures 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (state == CLEAR) begin
      out <= '0;
    end else begin
      out <= mem[address];
    end
  end
`else
  assign out = busy ? '0 : mem[address];
`endif

endmodule

// File: tb/tb_ram_n.sv
// tb/tb_ram_n.sv - directed self-checking bench for ram_n (default and 32x16 instances)
module tb_ram_n;

  logic        clk;
  logic        rst_n;
  logic [2:0]  address;
  logic [15:0] in;
  logic        load;
  logic        clear;
  logic [15:0] out;
  logic        busy;

  logic [3:0]  b_address;
  logic [31:0] b_in;
  logic        b_load;
  logic        b_clear;
  logic [31:0] b_out;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_mem [8];

  ram_n u_dut (
    .clk(clk), .rst_n(rst_n), .address(address), .in(in),
    .load(load), .clear(clear), .out(out), .busy(busy)
  );

  ram_n #(.WIDTH(32), .ADDR_WIDTH(4)) u_big (
    .clk(clk), .rst_n(rst_n), .address(b_address), .in(b_in),
    .load(b_load), .clear(b_clear), .out(b_out), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input int a, input logic [15:0] exp, input string tag);
    address = 3'(a);
    load    = 1'b0;
`ifdef RAM_N_REGOUT_EN
    tick();
`else
    #1;
`endif
    check(tag, {16'h0, out}, {16'h0, exp});
  endtask

  task automatic big_read_chk(input int a, input logic [31:0] exp, input string tag);
    b_address = 4'(a);
    b_load    = 1'b0;
`ifdef RAM_N_REGOUT_EN
    tick();
`else
    #1;
`endif
    check(tag, b_out, exp);
  endtask

  task automatic write_w(input int a, input logic [15:0] d);
    address = 3'(a);
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Counts edges until busy falls on each instance; pulses clear on both at
  // the given edge index (0 = never). Returns 0 if busy never falls.
  task automatic measure(input int clr_at, output int n_small, output int n_big);
    n_small = 0;
    n_big   = 0;
    for (int i = 1; i <= 40; i++) begin
      clear   = (i == clr_at);
      b_clear = (i == clr_at);
      tick();
      if (busy)   check("out_zero_in_sweep", {16'h0, out}, 32'h0);
      if (!busy   && n_small == 0) n_small = i;
      if (!b_busy && n_big   == 0) n_big   = i;
      if (n_small != 0 && n_big != 0) break;
    end
    clear   = 1'b0;
    b_clear = 1'b0;
  endtask

  initial begin
    int ns, nb;
    rst_n = 1'b0; address = '0; in = '0; load = 1'b0; clear = 1'b0;
    b_address = '0; b_in = '0; b_load = 1'b0; b_clear = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_out", {16'h0, out}, 32'h0);
    check("rst_big_busy", {31'h0, b_busy}, 32'h1);
    check("rst_big_out", b_out, 32'h0);
    rst_n = 1'b1;

    measure(0, ns, nb);
    check("sweep_len_8", ns, 8);
    check("sweep_len_16", nb, 16);
    for (int i = 0; i < 8; i++) read_chk(i, 16'h0, "post_reset_zero");

    // write / read
    foreach (exp_mem[i]) exp_mem[i] = 16'h0;
    write_w(0, 16'h1234); exp_mem[0] = 16'h1234;
    write_w(7, 16'hBEEF); exp_mem[7] = 16'hBEEF;
    write_w(3, 16'h00FF); exp_mem[3] = 16'h00FF;
    for (int i = 0; i < 8; i++) read_chk(i, exp_mem[i], "write_read");

    // load=0 leaves contents untouched
    for (int i = 0; i < 6; i++) begin
      address = 3'($urandom_range(0, 7));
      in      = 16'($urandom);
      load    = 1'b0;
      tick();
    end
    for (int i = 0; i < 8; i++) read_chk(i, exp_mem[i], "no_load_hold");

    // fill, then clear with a same-cycle load that must be dropped
    for (int i = 0; i < 8; i++) write_w(i, 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) read_chk(i, 16'h1000 + 16'(i), "fill");
    address = 3'd2; in = 16'hAAAA; load = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy", {31'h0, busy}, 32'h1);
    ns = 0;
    for (int i = 1; i <= 40; i++) begin
      address = 3'(i); in = 16'hFFFF; load = 1'b1;
      tick();
      if (busy) check("clear_out_zero", {16'h0, out}, 32'h0);
      else begin ns = i; break; end
    end
    load = 1'b0;
    check("clear_len", ns, 8);
    for (int i = 0; i < 8; i++) read_chk(i, 16'h0, "after_clear_zero");

    // reset mid-sweep (ptr=4), then a clear during the restarted sweep
    clear = 1'b1; b_clear = 1'b1;
    tick();
    clear = 1'b0; b_clear = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h1);
    check("midrst_out", {16'h0, out}, 32'h0);
    repeat (2) tick();
    check("midrst_busy_held", {31'h0, busy}, 32'h1);
    rst_n = 1'b1;
    measure(3, ns, nb);
    check("restart_len_8", ns, 8);
    check("restart_len_16", nb, 16);

    // 32x16 instance
    b_address = 4'd15; b_in = 32'hDEADBEEF; b_load = 1'b1; tick();
    b_address = 4'd0;  b_in = 32'h12345678; tick();
    b_load = 1'b0;
    big_read_chk(15, 32'hDEADBEEF, "big_15");
    big_read_chk(0, 32'h12345678, "big_0");
    big_read_chk(8, 32'h0, "big_8");
    b_clear = 1'b1; tick(); b_clear = 1'b0;
    nb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!b_busy) begin nb = i; break; end
    end
    check("big_clear_len", nb, 16);
    big_read_chk(15, 32'h0, "big_15_cleared");
    big_read_chk(0, 32'h0, "big_0_cleared");

    // same-address read and write
    write_w(1, 16'h1111);
    read_chk(1, 16'h1111, "rw_pre");
    address = 3'd1; in = 16'h5A5A; load = 1'b1;
`ifdef RAM_N_REGOUT_EN
    tick();
    load = 1'b0;
    check("rw_old_after_edge", {16'h0, out}, 32'h1111);
    tick();
    check("rw_new_next_edge", {16'h0, out}, 32'h5A5A);
`else
    #1;
    check("rw_old_before_edge", {16'h0, out}, 32'h1111);
    tick();
    load = 1'b0;
    check("rw_new_after_edge", {16'h0, out}, 32'h5A5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
